// File: rtl/gen_stream_sink.sv
// Consumer end of the generator stream interface: launches a run, buffers the
// accepted beats in a small first-word-fall-through FIFO and keeps per-run statistics.
module gen_stream_sink #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             __clock,
    input  logic             __reset,
    input  logic             start,
    output logic             gen_start,
    input  logic             gen_valid,
    input  logic             gen_done,
    input  logic [WIDTH-1:0] gen_data,
    output logic             gen_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] sum,
    output logic             run_done
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];
    localparam logic [AW:0] OCC_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        COLLECT,
        DRAIN,
        FINISH
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic             gen_start_q;
    logic             gen_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             busy_q;
    logic             run_done_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] sum_q;
    logic             gen_xfer;
    logic             push;
    logic             term;
    logic             pop;

    always_comb begin
        gen_xfer = (state_q == COLLECT) && gen_valid && gen_ready_q;
        push     = gen_xfer && !gen_done;
        term     = gen_xfer && gen_done;
        pop      = out_valid_q && out_ready;
        wptr_d   = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d   = pop  ? rptr_q + PTR_ONE : rptr_q;
        occ_d    = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OCC_ONE;
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_ONE;
        end
        // A beat written this cycle into the slot that becomes the head must bypass the array.
        out_data_d = (push && (rptr_d == wptr_q)) ? gen_data : mem_q[rptr_d];
    end

    always_ff @(posedge __clock) begin
        if (push) begin
            mem_q[wptr_q] <= gen_data;
        end
    end

    always_ff @(posedge __clock or negedge __reset) begin
        if (!__reset) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            occ_q       <= '0;
            gen_start_q <= 1'b0;
            gen_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            run_done_q  <= 1'b0;
            count_q     <= '0;
            sum_q       <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            occ_q       <= occ_d;
            out_valid_q <= (occ_d != '0);
            out_data_q  <= out_data_d;
            gen_start_q <= 1'b0;
            gen_ready_q <= 1'b0;
            run_done_q  <= 1'b0;

            if (push) begin
                if (count_q != {CNT_W{1'b1}}) begin
                    count_q <= count_q + CNT_ONE;
                end
                sum_q <= sum_q + gen_data;
            end

            // gen_ready is registered from next occupancy, so it always reflects !full
            // of the occupancy seen on the following edge (no pass-through when full).
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= LAUNCH;
                        gen_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        count_q     <= '0;
                        sum_q       <= '0;
                    end
                end
                LAUNCH: begin
                    state_q     <= COLLECT;
                    gen_ready_q <= (occ_d != FULL_OCC);
                end
                COLLECT: begin
                    if (term) begin
                        state_q <= DRAIN;
                    end else begin
                        gen_ready_q <= (occ_d != FULL_OCC);
                    end
                end
                DRAIN: begin
                    if (occ_q == '0) begin
                        state_q    <= FINISH;
                        run_done_q <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gen_start = gen_start_q;
    assign gen_ready = gen_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign count     = count_q;
    assign sum       = sum_q;
    assign run_done  = run_done_q;

endmodule
